// File: rtl/vga_pkg.sv
// Shared types and screen constants for the VGA pixel-port arbiter.
// The defaults describe the 160x120 screen with 3-bit colour.
package vga_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam int unsigned SCREEN_XMAX = 159;
  localparam int unsigned SCREEN_YMAX = 119;

  localparam int unsigned VGA_XW = 8;
  localparam int unsigned VGA_YW = 7;
  localparam int unsigned VGA_CW = 3;

endpackage

// File: rtl/vga_pixel_reg.sv
// Registered pixel output stage.
// Out-of-screen pixels still load the coordinate registers but are never plotted.
module vga_pixel_reg
  import vga_pkg::*;
#(
  parameter int unsigned XW   = VGA_XW,
  parameter int unsigned YW   = VGA_YW,
  parameter int unsigned CW   = VGA_CW,
  parameter int unsigned XMAX = SCREEN_XMAX,
  parameter int unsigned YMAX = SCREEN_YMAX,
  parameter int unsigned DW   = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          xfer_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [CW-1:0] colour_i,
  output logic [XW-1:0] vga_x_o,
  output logic [YW-1:0] vga_y_o,
  output logic [CW-1:0] vga_colour_o,
  output logic          vga_plot_o,
  output logic [DW-1:0] drop_cnt_o
);

  localparam logic [XW-1:0] XMaxC = XW'(XMAX);
  localparam logic [YW-1:0] YMaxC = YW'(YMAX);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          plot_q, plot_d;
  logic [DW-1:0] drop_q, drop_d;
  logic          in_range;

  assign in_range = (x_i <= XMaxC) && (y_i <= YMaxC);

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    drop_d   = drop_q;
    if (xfer_i) begin
      x_d      = x_i;
      y_d      = y_i;
      colour_d = colour_i;
      plot_d   = in_range;
      // Saturate rather than wrap so a large drop count is never mistaken for a small one.
      if (!in_range && (drop_q != {DW{1'b1}})) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      drop_q   <= drop_d;
    end
  end

  assign vga_x_o      = x_q;
  assign vga_y_o      = y_q;
  assign vga_colour_o = colour_q;
  assign vga_plot_o   = plot_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Two-requester burst arbiter for the VGA adapter pixel-write port.
// A requester owns the port from grant until it transfers a pixel flagged last.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned XW   = VGA_XW,
  parameter int unsigned YW   = VGA_YW,
  parameter int unsigned CW   = VGA_CW,
  parameter int unsigned XMAX = SCREEN_XMAX,
  parameter int unsigned YMAX = SCREEN_YMAX,
  parameter int unsigned DW   = 8
) (
  input  logic          CLOCK_50,
  input  logic          Reset,
  input  logic          prio_mode,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [XW-1:0] r0_x,
  input  logic [YW-1:0] r0_y,
  input  logic [CW-1:0] r0_colour,
  input  logic          r0_last,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [XW-1:0] r1_x,
  input  logic [YW-1:0] r1_y,
  input  logic [CW-1:0] r1_colour,
  input  logic          r1_last,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic          busy,
  output logic          grant,
  output logic [DW-1:0] drop_cnt
);

  arb_state_e    state_q, state_d;
  logic          last_served_q, last_served_d;
  logic          xfer;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_colour;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    xfer          = 1'b0;
    pix_x         = r0_x;
    pix_y         = r0_y;
    pix_colour    = r0_colour;
    unique case (state_q)
      StIdle: begin
        if (r0_valid && r1_valid) begin
          // last_served=1 means requester 1 went last, so round-robin favours 0.
          state_d = (prio_mode || last_served_q) ? StOwn0 : StOwn1;
        end else if (r0_valid) begin
          state_d = StOwn0;
        end else if (r1_valid) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        r0_ready = 1'b1;
        xfer     = r0_valid;
        if (r0_valid && r0_last) begin
          state_d       = StIdle;
          last_served_d = 1'b0;
        end
      end
      StOwn1: begin
        r1_ready   = 1'b1;
        xfer       = r1_valid;
        pix_x      = r1_x;
        pix_y      = r1_y;
        pix_colour = r1_colour;
        if (r1_valid && r1_last) begin
          state_d       = StIdle;
          last_served_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign grant = (state_q == StOwn1);

  vga_pixel_reg #(
    .XW  (XW),
    .YW  (YW),
    .CW  (CW),
    .XMAX(XMAX),
    .YMAX(YMAX),
    .DW  (DW)
  ) u_pixel_reg (
    .clk_i       (CLOCK_50),
    .rst_i       (Reset),
    .xfer_i      (xfer),
    .x_i         (pix_x),
    .y_i         (pix_y),
    .colour_i    (pix_colour),
    .vga_x_o     (vga_x),
    .vga_y_o     (vga_y),
    .vga_colour_o(vga_colour),
    .vga_plot_o  (vga_plot),
    .drop_cnt_o  (drop_cnt)
  );

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter; accepted pixels go into a scoreboard
// keyed by the cycle their registered output is due.
module tb_vga_plot_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       prio_mode = 1'b0;
  logic       r0_valid = 1'b0, r0_ready, r0_last = 1'b0;
  logic [7:0] r0_x = '0;
  logic [6:0] r0_y = '0;
  logic [2:0] r0_colour = '0;
  logic       r1_valid = 1'b0, r1_ready, r1_last = 1'b0;
  logic [7:0] r1_x = '0;
  logic [6:0] r1_y = '0;
  logic [2:0] r1_colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, grant;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       plot;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n = 0;
  int   cnt[2];

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter dut (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .prio_mode (prio_mode),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_x      (r0_x),
    .r0_y      (r0_y),
    .r0_colour (r0_colour),
    .r0_last   (r0_last),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_x      (r1_x),
    .r1_y      (r1_y),
    .r1_colour (r1_colour),
    .r1_last   (r1_last),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy),
    .grant     (grant),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rdy(input string tag, input logic e0, input logic e1);
    chk({tag, "_r0_ready"}, 32'(r0_ready), 32'(e0));
    chk({tag, "_r1_ready"}, 32'(r1_ready), 32'(e1));
  endtask

  task automatic set_r(input int k, input logic v, input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input logic l);
    if (k == 0) begin
      r0_valid = v; r0_x = x; r0_y = y; r0_colour = c; r0_last = l;
    end else begin
      r1_valid = v; r1_x = x; r1_y = y; r1_colour = c; r1_last = l;
    end
  endtask

  task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      input logic plot);
    exp_t e;
    e.x = x; e.y = y; e.c = c; e.plot = plot; e.due = cyc_n + 1;
    sb.push_back(e);
  endtask

  // Compare the registered output against whatever the scoreboard says is due now.
  task automatic monitor();
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      e = sb.pop_front();
      chk("pix_x", 32'(vga_x), 32'(e.x));
      chk("pix_y", 32'(vga_y), 32'(e.y));
      chk("pix_colour", 32'(vga_colour), 32'(e.c));
      chk("pix_plot", 32'(vga_plot), 32'(e.plot));
    end else begin
      chk("idle_plot", 32'(vga_plot), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc_n++;
    monitor();
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_x", 32'(vga_x), 32'd0);
    chk("rst_y", 32'(vga_y), 32'd0);
    chk("rst_colour", 32'(vga_colour), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    check_rdy("rst", 1'b0, 1'b0);
    Reset = 1'b0;

    // r0 four-pixel burst, r1 idle
    set_r(0, 1'b1, 8'd0, 7'd0, 3'b101, 1'b0);
    check_rdy("t1_idle", 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_r(0, 1'b1, 8'(i), 7'd0, 3'b101, 1'(i == 3));
      check_rdy("t1_own", 1'b1, 1'b0);
      chk("t1_busy", 32'(busy), 32'd1);
      push(8'(i), 7'd0, 3'b101, 1'b1);
      step();
    end
    chk("t1_busy_end", 32'(busy), 32'd0);
    set_r(0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    step();

    // Fresh reset so round-robin starts with requester 0
    Reset = 1'b1;
    step();
    Reset = 1'b0;

    // Round-robin, both requesters continuously valid with 2-pixel bursts
    prio_mode = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int b = 0; b < 4; b++) begin
      int k;
      k = b % 2;
      set_r(0, 1'b1, 8'(10 + cnt[0]), 7'd10, 3'd1, 1'b0);
      set_r(1, 1'b1, 8'(20 + cnt[1]), 7'd20, 3'd2, 1'b0);
      check_rdy("t2_gap", 1'b0, 1'b0);
      chk("t2_gap_busy", 32'(busy), 32'd0);
      step();
      for (int j = 0; j < 2; j++) begin
        set_r(k, 1'b1, 8'(10 * (k + 1) + cnt[k]), 7'(10 * (k + 1)), 3'(k + 1), 1'(j == 1));
        check_rdy("t2_own", 1'(k == 0), 1'(k == 1));
        chk("t2_grant", 32'(grant), 32'(k));
        push(8'(10 * (k + 1) + cnt[k]), 7'(10 * (k + 1)), 3'(k + 1), 1'b1);
        cnt[k]++;
        step();
      end
    end

    // Fixed priority: r0 wins every time both are valid
    prio_mode = 1'b1;
    set_r(1, 1'b1, 8'd50, 7'd50, 3'd6, 1'b1);
    for (int b = 0; b < 2; b++) begin
      set_r(0, 1'b1, 8'(40 + b), 7'd40, 3'd3, 1'b1);
      check_rdy("t3_gap", 1'b0, 1'b0);
      step();
      check_rdy("t3_own0", 1'b1, 1'b0);
      chk("t3_grant0", 32'(grant), 32'd0);
      push(8'(40 + b), 7'd40, 3'd3, 1'b1);
      step();
    end
    set_r(0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    check_rdy("t3_gap1", 1'b0, 1'b0);
    step();
    check_rdy("t3_own1", 1'b0, 1'b1);
    chk("t3_grant1", 32'(grant), 32'd1);
    push(8'd50, 7'd50, 3'd6, 1'b1);
    step();
    set_r(1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    step();

    // Out-of-range pixels are consumed, not plotted, and counted
    prio_mode = 1'b0;
    set_r(1, 1'b1, 8'd160, 7'd5, 3'd7, 1'b0);
    step();
    check_rdy("t4_a", 1'b0, 1'b1);
    push(8'd160, 7'd5, 3'd7, 1'b0);
    step();
    set_r(1, 1'b1, 8'd159, 7'd120, 3'd4, 1'b0);
    check_rdy("t4_b", 1'b0, 1'b1);
    push(8'd159, 7'd120, 3'd4, 1'b0);
    step();
    set_r(1, 1'b1, 8'd159, 7'd119, 3'd2, 1'b1);
    check_rdy("t4_c", 1'b0, 1'b1);
    push(8'd159, 7'd119, 3'd2, 1'b1);
    step();
    set_r(1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_busy", 32'(busy), 32'd0);
    step();

    // Owner r0 stalls mid-burst while r1 waits
    set_r(0, 1'b1, 8'd1, 7'd1, 3'd1, 1'b0);
    step();
    push(8'd1, 7'd1, 3'd1, 1'b1);
    step();
    set_r(0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    set_r(1, 1'b1, 8'd70, 7'd70, 3'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_rdy("t5_stall", 1'b1, 1'b0);
      chk("t5_grant", 32'(grant), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      step();
    end
    set_r(0, 1'b1, 8'd2, 7'd1, 3'd1, 1'b1);
    check_rdy("t5_resume", 1'b1, 1'b0);
    push(8'd2, 7'd1, 3'd1, 1'b1);
    step();
    set_r(0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    step();
    check_rdy("t5_r1", 1'b0, 1'b1);
    push(8'd70, 7'd70, 3'd5, 1'b1);
    step();
    set_r(1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    step();

    // Reset asserted during OWN1 at the third pixel
    set_r(1, 1'b1, 8'd30, 7'd30, 3'd3, 1'b0);
    step();
    push(8'd30, 7'd30, 3'd3, 1'b1);
    step();
    set_r(1, 1'b1, 8'd31, 7'd30, 3'd3, 1'b0);
    push(8'd31, 7'd30, 3'd3, 1'b1);
    step();
    set_r(1, 1'b1, 8'd32, 7'd30, 3'd3, 1'b0);
    check_rdy("t6_pre", 1'b0, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_plot", 32'(vga_plot), 32'd0);
    chk("t6_x", 32'(vga_x), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    check_rdy("t6_rst", 1'b0, 1'b0);
    #1;
    Reset = 1'b0;
    prio_mode = 1'b0;
    set_r(0, 1'b1, 8'd5, 7'd6, 3'd7, 1'b1);
    set_r(1, 1'b1, 8'd32, 7'd30, 3'd3, 1'b1);
    step();
    check_rdy("t6_after", 1'b1, 1'b0);
    chk("t6_grant", 32'(grant), 32'd0);
    push(8'd5, 7'd6, 3'd7, 1'b1);
    step();
    set_r(0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    set_r(1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    step();
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between two drawing engines. Typical pairing: requester 0 is the screen-fill/clear engine, requester 1 is the Bresenham circle engine. Grants are per burst: a requester keeps the port until it flags its last pixel. Output is registered and drives the adapter directly. Out-of-screen pixels are consumed but never plotted.

Parameters:
XW, 8, x coordinate width
YW, 7, y coordinate width
CW, 3, colour width
XMAX, 159, largest plottable x
YMAX, 119, largest plottable y
DW, 8, width of the dropped-pixel counter

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
prio_mode  in  1  0 = round-robin between bursts, 1 = fixed priority to requester 0
r0_valid  in  1  requester 0 presents a pixel
r0_ready  out  1  requester 0 pixel accepted this cycle when valid&ready
r0_x  in  XW  requester 0 x
r0_y  in  YW  requester 0 y
r0_colour  in  CW  requester 0 colour
r0_last  in  1  final pixel of requester 0 burst
r1_valid, r1_ready, r1_x, r1_y, r1_colour, r1_last: same as r0_* for requester 1
vga_x  out  XW  registered x to adapter
vga_y  out  YW  registered y to adapter
vga_colour  out  CW  registered colour to adapter
vga_plot  out  1  registered write strobe to adapter
busy  out  1  high whenever state is not IDLE
grant  out  1  index of the current owner, valid while busy
drop_cnt  out  DW  saturating count of out-of-range pixels consumed

Behaviour:
- Reset: state=IDLE; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0; drop_cnt=0; last_served=1, so requester 0 wins the first round-robin decision; busy=0; grant=0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: go to OWN of that requester.
  - Both valid, prio_mode=1: go to OWN0.
  - Both valid, prio_mode=0: go to the requester that is not last_served.
  - prio_mode is sampled only in IDLE. Changing it mid-burst has no effect on the current owner.
- OWNk:
  - rk_ready=1 combinationally. The other ready stays 0. Both readies are 0 in IDLE.
  - A transfer is rk_valid&rk_ready.
  - A transfer with rk_last=1 sets last_served=k and returns to IDLE next cycle.
  - With rk_valid low, hold OWNk indefinitely (no timeout). Requesters must finish their bursts.
- Arbitration bubble: the first pixel of a burst is accepted at the earliest one cycle after valid is seen in IDLE. Back-to-back bursts insert exactly one IDLE cycle.
- Output latency is 1 cycle. On a transfer, vga_x/y/colour load the requester's values.
  - In range (x<=XMAX and y<=YMAX): vga_plot=1 the next cycle.
  - Out of range: vga_plot=0, vga_x/y/colour still load, and drop_cnt increments, saturating at 2^DW-1.
- With no transfer, vga_plot=0 and vga_x/y/colour hold their values.
- Single-pixel burst: valid with last=1 on the first accepted beat gives OWNk for 1 cycle, then IDLE.
- Reset mid-burst: the burst is aborted immediately. Requesters must restart after Reset deasserts. vga_plot goes low asynchronously.
- Ready never depends on valid of the same requester, so there is no combinational loop.

Decomposition:
- Shared package vga_pkg holds:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - constants SCREEN_XMAX=159 and SCREEN_YMAX=119;
  - pixel widths XW/YW/CW for the 160x120, 3-bit-colour configuration.
- One natural sub-module: vga_pixel_reg. It is the registered output stage with range check and drop counter, fed by the muxed pixel and a transfer strobe.

Test Plan:
- Reset, then r0 sends a 4-pixel burst (0,0),(1,0),(2,0),(3,0) colour 3'b101, last on the 4th, r1 idle -> r0_ready from cycle 1. vga_plot pulses 4 consecutive cycles, each one cycle after its transfer, with matching x/y. busy drops after the last beat.
- prio_mode=0, both valid continuously with 2-pixel bursts -> grant order 0,1,0,1. One IDLE cycle between bursts. r1_ready never high while grant=0.
- prio_mode=1, both continuously valid -> requester 0 always wins. Requester 1 is granted only after r0_valid is dropped in IDLE.
- r1 sends (160,5) then (159,120) then (159,119), last on the 3rd -> all three accepted. vga_plot=0,0,1. drop_cnt=2.
- Owner r0 stalls (valid low 5 cycles) mid-burst while r1 is valid -> state stays OWN0, r1_ready=0, vga_plot=0 throughout. Resumes when r0_valid returns.
- Assert Reset during OWN1 at the 3rd pixel -> outputs 0 immediately, state IDLE. After release with both valid and prio_mode=0, r0 is granted first.
